// File: rtl/fp_div_bf16_seq.sv
// fp_div_bf16_seq: sequential BF16 divider (A / B).
// Uses a restoring mantissa divider that produces one quotient bit per cycle,
// then applies round-to-nearest-even and flushes subnormals to zero.
// Latency is fixed: an operand pair accepted at edge T has out_valid sampled high
// at edge T+13. Throughput is one divide every 14 cycles.
// Optional feature: define FP_DIV_BF16_STATUS_EN to add the 5-bit status port
// {NV, DZ, OF, UF, NX}.
module fp_div_bf16_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] inA,
   input  logic [15:0] inB,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out
`ifdef FP_DIV_BF16_STATUS_EN
   ,
   output logic [4:0]  status
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_ROUND, S_DONE} state_t;

   state_t      state;
   logic        in_ready_q;
   logic        out_valid_q;
   logic [15:0] out_q;
   logic [3:0]  cnt;
   logic [8:0]  r;
   logic [7:0]  d;
   logic [10:0] q;
   logic        sign;
   logic [7:0]  ea;
   logic [7:0]  eb;
   logic        special;
   logic [15:0] spec_res;

   // Operand classification; subnormals (exponent 0) count as zero
   logic [7:0]  a_exp, b_exp;
   logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, sgn_in;
   logic        dec_special;
   logic [15:0] dec_res;

   // One restoring step
   logic        q_bit;
   logic [7:0]  r_sub;
   logic [8:0]  r_next;

   // Normalise / round / range check
   logic [7:0]        man;
   logic              guard, sticky, rnd;
   logic [8:0]        man_r;
   logic signed [9:0] e_pre, e_fin;
   logic [15:0]       rnd_res;

`ifdef FP_DIV_BF16_STATUS_EN
   logic [4:0] status_q;
   logic       spec_nv, spec_dz;
   logic       dec_nv, dec_dz;
   logic       rnd_of, rnd_uf, rnd_nx;
`endif

   assign a_exp  = inA[14:7];
   assign b_exp  = inB[14:7];
   assign a_zero = (a_exp == 8'd0);
   assign b_zero = (b_exp == 8'd0);
   assign a_inf  = (a_exp == 8'hFF) && (inA[6:0] == 7'd0);
   assign b_inf  = (b_exp == 8'hFF) && (inB[6:0] == 7'd0);
   assign a_nan  = (a_exp == 8'hFF) && (inA[6:0] != 7'd0);
   assign b_nan  = (b_exp == 8'hFF) && (inB[6:0] != 7'd0);
   assign sgn_in = inA[15] ^ inB[15];

   // Decode special operand combinations at accept time; these override the datapath
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      dec_special = 1'b1;
      dec_res     = 16'h0000;
`ifdef FP_DIV_BF16_STATUS_EN
      dec_nv      = 1'b0;
      dec_dz      = 1'b0;
`endif
      if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
         dec_res = 16'h7FC0;
`ifdef FP_DIV_BF16_STATUS_EN
         dec_nv  = 1'b1;
`endif
      end else if (b_zero && !a_inf) begin
         dec_res = {sgn_in, 15'h7F80};
`ifdef FP_DIV_BF16_STATUS_EN
         dec_dz  = 1'b1;
`endif
      end else if (a_inf) begin
         // inf / finite, including inf / 0, which is exact and raises no divide-by-zero
         dec_res = {sgn_in, 15'h7F80};
      end else if (a_zero || b_inf) begin
         dec_res = {sgn_in, 15'h0000};
      end else begin
         dec_special = 1'b0;
      end
   end

   // Restoring step: subtract when possible, then shift the partial remainder left
   always_comb begin
      q_bit  = (r >= {1'b0, d});
      r_sub  = q_bit ? 8'(r - {1'b0, d}) : r[7:0];
      r_next = {r_sub, 1'b0};
   end

   // Normalise the 11-bit quotient, round to nearest even and check the exponent range
   always_comb begin
      if (q[10]) begin
         man    = q[10:3];
         guard  = q[2];
         sticky = (|q[1:0]) | (|r);
      end else begin
         man    = q[9:2];
         guard  = q[1];
         sticky = q[0] | (|r);
      end
      e_pre = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127
              - (q[10] ? 10'sd0 : 10'sd1);
      rnd   = guard & (sticky | man[0]);
      man_r = {1'b0, man} + {8'd0, rnd};
      // A mantissa carry-out leaves 1.0000000, so the fraction bits are already zero
      e_fin = e_pre + (man_r[8] ? 10'sd1 : 10'sd0);
`ifdef FP_DIV_BF16_STATUS_EN
      rnd_of = 1'b0;
      rnd_uf = 1'b0;
      rnd_nx = guard | sticky;
`endif
      if (e_fin >= 10'sd255) begin
         rnd_res = {sign, 15'h7F80};
`ifdef FP_DIV_BF16_STATUS_EN
         rnd_of  = 1'b1;
         rnd_nx  = 1'b1;
`endif
      end else if (e_fin <= 10'sd0) begin
         rnd_res = {sign, 15'h0000};
`ifdef FP_DIV_BF16_STATUS_EN
         rnd_uf  = 1'b1;
         rnd_nx  = 1'b1;
`endif
      end else begin
         rnd_res = {sign, e_fin[7:0], man_r[6:0]};
      end
   end

   // Control FSM and datapath registers; reset aborts any divide in flight
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state       <= S_IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_q       <= 16'h0000;
         cnt         <= 4'd0;
         r           <= 9'd0;
         d           <= 8'd0;
         q           <= 11'd0;
         sign        <= 1'b0;
         ea          <= 8'd0;
         eb          <= 8'd0;
         special     <= 1'b0;
         spec_res    <= 16'h0000;
`ifdef FP_DIV_BF16_STATUS_EN
         status_q    <= 5'd0;
         spec_nv     <= 1'b0;
         spec_dz     <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid && in_ready_q) begin
                  sign       <= sgn_in;
                  ea         <= a_exp;
                  eb         <= b_exp;
                  r          <= {2'b01, inA[6:0]};
                  d          <= {1'b1, inB[6:0]};
                  q          <= 11'd0;
                  cnt        <= 4'd0;
                  special    <= dec_special;
                  spec_res   <= dec_res;
`ifdef FP_DIV_BF16_STATUS_EN
                  spec_nv    <= dec_nv;
                  spec_dz    <= dec_dz;
`endif
                  in_ready_q <= 1'b0;
                  state      <= S_DIV;
               end
            end
            S_DIV: begin
               r   <= r_next;
               q   <= {q[9:0], q_bit};
               cnt <= cnt + 4'd1;
               if (cnt == 4'd10) state <= S_ROUND;
            end
            S_ROUND: begin
               out_q       <= special ? spec_res : rnd_res;
`ifdef FP_DIV_BF16_STATUS_EN
               status_q    <= special ? {spec_nv, spec_dz, 3'b000}
                                      : {2'b00, rnd_of, rnd_uf, rnd_nx};
`endif
               out_valid_q <= 1'b1;
               state       <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state       <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out       = out_q;
`ifdef FP_DIV_BF16_STATUS_EN
   assign status    = status_q;
`endif

endmodule

// File: tb/tb_fp_div_bf16_seq.sv
// tb_fp_div_bf16_seq: scoreboard bench for the sequential BF16 divider.
// Expected results come from an integer long-division model and are queued at
// accept time, then popped when the output handshake happens.
module tb_fp_div_bf16_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] inA, inB;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out;
`ifdef FP_DIV_BF16_STATUS_EN
   logic [4:0]  status;
`endif

   typedef struct packed {
      logic [15:0] res;
      logic [4:0]  flags;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   t_acc  = 0;

   fp_div_bf16_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .inA       (inA),
      .inB       (inB),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out)
`ifdef FP_DIV_BF16_STATUS_EN
      ,
      .status    (status)
`endif
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Index of the most recent rising edge
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Reference: exact integer quotient with 16 fraction bits, RNE, flush-to-zero
   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
      exp_t            x;
      logic            s, az, ai, an, bz, bi, bn, g, st;
      int              ea, eb, e;
      longint unsigned num, quo, rem, ma, mb;
      int unsigned     man, m;
      s  = a[15] ^ b[15];
      ea = int'(a[14:7]);
      eb = int'(b[14:7]);
      az = (ea == 0);
      bz = (eb == 0);
      ai = (ea == 255) && (a[6:0] == 7'd0);
      bi = (eb == 255) && (b[6:0] == 7'd0);
      an = (ea == 255) && (a[6:0] != 7'd0);
      bn = (eb == 255) && (b[6:0] != 7'd0);
      x.flags = 5'b00000;
      if (an || bn || (az && bz) || (ai && bi)) begin
         x.res = 16'h7FC0; x.flags = 5'b10000;
      end else if (bz && !ai) begin
         x.res = {s, 15'h7F80}; x.flags = 5'b01000;
      end else if (ai) begin
         x.res = {s, 15'h7F80};
      end else if (az || bi) begin
         x.res = {s, 15'h0000};
      end else begin
         ma  = 128 + longint'(a[6:0]);
         mb  = 128 + longint'(b[6:0]);
         num = ma << 16;
         quo = num / mb;
         rem = num % mb;
         if (quo >= 65536) begin
            e   = ea - eb + 127;
            man = int'((quo >> 9) & 255);
            g   = quo[8];
            st  = ((quo & 255) != 0) || (rem != 0);
         end else begin
            e   = ea - eb + 126;
            man = int'((quo >> 8) & 255);
            g   = quo[7];
            st  = ((quo & 127) != 0) || (rem != 0);
         end
         m = man + ((g && (st || man[0])) ? 1 : 0);
         if (m == 256) begin
            m = 128;
            e = e + 1;
         end
         if (e >= 255) begin
            x.res = {s, 15'h7F80}; x.flags = 5'b00101;
         end else if (e <= 0) begin
            x.res = {s, 15'h0000}; x.flags = 5'b00011;
         end else begin
            x.res   = {s, e[7:0], m[6:0]};
            x.flags = {4'b0000, g | st};
         end
      end
      return x;
   endfunction

   // Output monitor: compare on every output handshake
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         check("sb_nonempty", (sb.size() > 0), 1);
         if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("result", out, e.res);
`ifdef FP_DIV_BF16_STATUS_EN
            check("status", status, e.flags);
`endif
         end
      end
   end

   task automatic present(input logic [15:0] a, input logic [15:0] b);
      inA      = a;
      inB      = b;
      in_valid = 1'b1;
   endtask

   // Wait for acceptance, queue expectation, then keep junk on the inputs briefly
   task automatic take(input logic [15:0] a, input logic [15:0] b);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 40);
      check("accept_ready", in_ready, 1);
      t_acc = cyc + 1;
      sb.push_back(model(a, b));
      @(posedge clk); #1;
      inA = 16'h3F80;
      inB = 16'h4000;
      @(negedge clk);
      check("in_ready_busy", in_ready, 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send(input logic [15:0] a, input logic [15:0] b);
      @(posedge clk); #1;
      present(a, b);
      take(a, b);
   endtask

   task automatic wait_out();
      int n = 0;
      while (!out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("out_valid_seen", out_valid, 1);
      check("latency", cyc + 1 - t_acc, 13);
   endtask

   // Full divide with out_ready high; in_ready returns the cycle after the handshake
   task automatic do_div(input logic [15:0] a, input logic [15:0] b);
      send(a, b);
      wait_out();
      @(negedge clk);
      check("in_ready_after_hs", in_ready, 1);
      check("out_valid_after_hs", out_valid, 0);
   endtask

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] snap;
      logic [15:0] ra, rb;
      int          p, vcount;
      logic [15:0] vec_a [12] = '{16'h3F80, 16'h3F80, 16'hC0C0, 16'h4000, 16'h0000, 16'h7F7F,
                                  16'h0000, 16'h7F80, 16'h7FC1, 16'h7F80, 16'h0080, 16'h0001};
      logic [15:0] vec_b [12] = '{16'h3F80, 16'h4040, 16'h4000, 16'h0000, 16'h0000, 16'h3F00,
                                  16'hC000, 16'h4000, 16'h3F80, 16'h7F80, 16'h4000, 16'h3F80};

      rst       = 1'b1;
      in_valid  = 1'b0;
      inA       = 16'h0000;
      inB       = 16'h0000;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out", out, 16'h0000);
`ifdef FP_DIV_BF16_STATUS_EN
      check("rst_status", status, 5'd0);
`endif

      // Directed vectors: plan cases, specials, underflow and a subnormal operand
      for (int i = 0; i < 12; i++) do_div(vec_a[i], vec_b[i]);

      // Random normal operands
      for (int i = 0; i < 8; i++) begin
         ra = {1'($urandom_range(0, 1)), 8'($urandom_range(90, 170)), 7'($urandom_range(0, 127))};
         rb = {1'($urandom_range(0, 1)), 8'($urandom_range(90, 170)), 7'($urandom_range(0, 127))};
         do_div(ra, rb);
      end

      // Backpressure: hold the result for 5 cycles, then handshake with a new operand waiting
      @(posedge clk); #1;
      out_ready = 1'b0;
      send(16'h3F80, 16'h4040);
      wait_out();
      snap = out;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_out_stable", out, snap);
         check("bp_out_valid", out_valid, 1);
         check("bp_in_ready", in_ready, 0);
      end
      @(posedge clk); #1;
      p         = cyc;
      out_ready = 1'b1;
      present(16'hC0C0, 16'h4000);
      take(16'hC0C0, 16'h4000);
      check("accept_after_hs", t_acc, p + 2);
      wait_out();
      @(negedge clk);
      check("in_ready_after_hs2", in_ready, 1);

      // Reset mid-divide: sampled at edge T+6, no result for that operation
      send(16'h4000, 16'h3F80);
      while (cyc < t_acc + 5) @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      sb.delete();
      @(negedge clk);
      check("abort_in_ready", in_ready, 1);
      check("abort_out_valid", out_valid, 0);
      vcount = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid) vcount++;
      end
      check("abort_no_result", vcount, 0);
      do_div(16'h3F80, 16'h4040);

      check("sb_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fp_div_bf16_seq.md
# fp_div_bf16_seq

Sequential BF16 (FP16ALT: 1 sign, 8 exponent, 7 mantissa bits) divider computing A / B. It is the inverse-operation companion to the team's combinational BF16 multiplier. It has a valid/ready handshake on both sides and a fixed-latency restoring mantissa divider that produces one quotient bit per cycle. It sits beside the multiplier in the exp/softmax datapath, where it provides reciprocal and normalisation divides.

## Interface
- No parameters; format fixed to BF16.
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  divider can accept; high only in IDLE.
- `inA`  in  16  dividend, BF16.
- `inB`  in  16  divisor, BF16.
- `out_valid`  out  1  result valid; held until accepted.
- `out_ready`  in  1  consumer accepts result.
- `out`  out  16  quotient, BF16, registered.
- `status`  out  5  {NV, DZ, OF, UF, NX}; present only with `FP_DIV_BF16_STATUS_EN`.

## Operation
- States: IDLE → DIV (11 cycles) → ROUND (1 cycle) → DONE → IDLE.
- IDLE
  - On `in_valid & in_ready`, latch the operands.
  - Sign = sA^sB.
  - Subnormal inputs are flushed to zero.
  - Load remainder r = {1,mA} (9 bit), divisor d = {1,mB}, iteration counter = 0.
- DIV, per cycle (restoring step)
  - If r ≥ d: q bit = 1 and r -= d.
  - Then r <<= 1.
  - Shift the q bit into q[10:0], MSB first.
  - Counter 0..10; leave after counter = 10.
- ROUND
  - Normalisation:
    - If q[10] = 1: mantissa = q[10:3], guard = q[2], sticky = |q[1:0] | (r≠0).
    - Else: mantissa = q[9:2], guard = q[1], sticky = q[0] | (r≠0), exponent −1.
  - Exponent:
    - Computed in 10-bit signed arithmetic.
    - e = eA − eB + 127 − (q[10] ? 0 : 1).
  - Rounding (RNE):
    - Increment if guard & (sticky | mantissa LSB).
    - Mantissa carry-out sets e += 1.
  - Overflow: e ≥ 255 → ±inf (0x7F80 | sign), OF and NX.
  - Underflow: e ≤ 0 → ±0 (flush-to-zero), UF and NX.
  - Otherwise NX = guard | sticky.
- Special cases
  - Decoded at accept and override the result in ROUND. They still take the full latency.
  - Any NaN, 0/0 or inf/inf → canonical NaN 0x7FC0, NV (NV for sNaN only is not distinguished; NV on any NaN input).
  - Finite nonzero / 0 → ±inf, DZ.
  - inf / finite → ±inf.
  - 0 / nonzero finite, or finite / inf → ±0.
- DONE
  - `out_valid` = 1; `out` and `status` are stable.
  - On `out_ready`, go to IDLE.
- No overlap: a new operand is accepted only in IDLE. Throughput is one divide per 14 cycles with `out_ready` held high.

## Timing
- Reset values:
  - `in_ready` = 1 (IDLE), `out_valid` = 0, `out` = 0x0000, `status` = 0.
  - Counter, q and r cleared.
- Accept at cycle T → `out_valid` rises at T+13. Latency is independent of operand values.
- `in_ready` is low from T+1 until the cycle after the output handshake.
- `out_valid` and `out` hold indefinitely while `out_ready` = 0.
- An output handshake at cycle U → `out_valid` = 0 and `in_ready` = 1 at U+1.
- `out_ready` asserted early (before DONE) has no effect.
- `in_valid` outside IDLE is ignored; operands are not sampled.
- `rst` asserted in any state aborts the operation. The next cycle shows reset values and no result is produced.

## Configuration
- `FP_DIV_BF16_STATUS_EN`
  - Defined: `status` port exists. It is registered in ROUND and valid with `out_valid`.
  - Undefined: the port and the flag logic are removed. `out` is bit-identical to the defined case.

## Test plan
- 0x3F80 / 0x3F80 (1/1), accept at T → `out` = 0x3F80 at T+13, status 0.
- 0x3F80 / 0x4040 (1/3) → 0x3EAB (guard = 1, sticky = 1, round up), NX.
- 0xC0C0 / 0x4000 (−6/2) → 0xC040, exact, NX = 0.
- Special cases:
  - 0x4000 / 0x0000 → 0x7F80, DZ.
  - 0x0000 / 0x0000 → 0x7FC0, NV.
  - 0x7F7F / 0x3F00 → 0x7F80, OF and NX.
- Backpressure: hold `out_ready` = 0 for 5 cycles after `out_valid` → `out` stable and `in_ready` = 0 throughout. Handshake then → `in_ready` = 1 next cycle. A second divide is accepted immediately and completes 13 cycles later.
- Assert `rst` at T+6 mid-divide → `out_valid` never rises for that operation. `in_ready` = 1 at T+7, and the next divide produces the correct result.
